// File: rtl/isa_pkg.sv
// Shared ISA constants and issue FSM state type.
// Field positions refer to the 32-bit instruction word.
package isa_pkg;

    localparam int ILEN     = 32;
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 28;
    localparam int COND_BIT = 27;
    localparam int OP_W     = OP_MSB - OP_LSB + 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC mux.
// A redirect load takes priority over the sequential increment.
module pc_reg
    import isa_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load,
    input  logic [ILEN-1:0] target,
    output logic [ILEN-1:0] pc
);

    logic [ILEN-1:0] pc_q;
    logic [ILEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = target;
        end else if (inc) begin
            pc_d = pc_q + ILEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_issue.sv
// Fetch/issue FSM: fetches one word, presents it to the control
// unit, and redirects on branch. Stops fetching on the halt opcode.
module instr_issue
    import isa_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [OP_W-1:0] HALT_OP  = 4'b1111
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [ILEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [OP_W-1:0] op,
    output logic            cond,
    output logic [ILEN-1:0] instr,
    output logic [ILEN-1:0] pc_out,
    input  logic            branch_taken,
    input  logic [ILEN-1:0] branch_target,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [ILEN-1:0] buf_q, buf_d;
    logic [ILEN-1:0] pcb_q, pcb_d;
    logic [ILEN-1:0] pc;
    logic            pc_inc;
    logic            pc_load;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .inc    (pc_inc),
        .load   (pc_load),
        .target (branch_target),
        .pc     (pc)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pcb_d   = pcb_q;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        unique case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (imem_ack) begin
                    buf_d   = imem_rdata;
                    pcb_d   = pc;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    if (buf_q[OP_MSB:OP_LSB] == HALT_OP) begin
                        state_d = S_HALT;
                    end else begin
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // Redirect overrides any ack capture or sequential advance.
        if (branch_taken && state_q != S_HALT) begin
            pc_load = 1'b1;
            pc_inc  = 1'b0;
            buf_d   = '0;
            pcb_d   = '0;
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            buf_q   <= '0;
            pcb_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pcb_q   <= pcb_d;
        end
    end

    // Request is masked while reset holds the FSM in FETCH.
    assign imem_req    = (state_q == S_FETCH) && !rst;
    assign imem_addr   = pc;
    assign issue_valid = (state_q == S_ISSUE);
    assign halted      = (state_q == S_HALT);
    assign op          = buf_q[OP_MSB:OP_LSB];
    assign cond        = buf_q[COND_BIT];
    assign instr       = buf_q;
    assign pc_out      = pcb_q;

endmodule

// File: tb/tb_instr_issue.sv
// Directed test of instr_issue: fetch, stall, branch, wrap, halt, reset.
// Inputs change 1 ns after the rising edge; checks happen there too.
module tb_instr_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  op;
    logic        cond;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_issue #(
        .RESET_PC (32'h0000_0000),
        .HALT_OP  (4'b1111)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .op            (op),
        .cond          (cond),
        .instr         (instr),
        .pc_out        (pc_out),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        issue_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        tick();
        tick();
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_halt",  32'(halted), 32'd0);
        chk("rst_op",    32'(op), 32'd0);
        chk("rst_cond",  32'(cond), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pcout", pc_out, 32'd0);
        chk("rst_addr",  imem_addr, 32'd0);

        // Basic fetch and issue
        rst = 1'b0;
        #1;
        chk("f0_req",  32'(imem_req), 32'd1);
        chk("f0_addr", imem_addr, 32'd0);
        tick();
        chk("w0_req",  32'(imem_req), 32'd0);
        chk("w0_addr", imem_addr, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1800_0000;
        tick();
        imem_ack = 1'b0;
        chk("i0_valid", 32'(issue_valid), 32'd1);
        chk("i0_op",    32'(op), 32'd1);
        chk("i0_cond",  32'(cond), 32'd1);
        chk("i0_instr", instr, 32'h1800_0000);
        chk("i0_pcout", pc_out, 32'd0);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("f1_req",   32'(imem_req), 32'd1);
        chk("f1_addr",  imem_addr, 32'd4);
        chk("f1_valid", 32'(issue_valid), 32'd0);

        // Back-pressure for 5 cycles
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h2345_6789;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(issue_valid), 32'd1);
            chk("bp_instr", instr, 32'h2345_6789);
            chk("bp_op",    32'(op), 32'd2);
            chk("bp_pcout", pc_out, 32'd4);
            chk("bp_addr",  imem_addr, 32'd4);
            tick();
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("bp_next", imem_addr, 32'd8);

        // Branch in same cycle as ack
        tick();
        chk("br_wait", imem_addr, 32'd8);
        imem_ack      = 1'b1;
        imem_rdata    = 32'h5555_5555;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        chk("br_req",   32'(imem_req), 32'd1);
        chk("br_addr",  imem_addr, 32'h40);
        chk("br_valid", 32'(issue_valid), 32'd0);
        chk("br_instr", instr, 32'd0);
        tick();
        chk("br_novalid", 32'(issue_valid), 32'd0);

        // Branch together with handshake
        imem_ack   = 1'b1;
        imem_rdata = 32'h3000_0000;
        tick();
        imem_ack = 1'b0;
        chk("hb_pcout", pc_out, 32'h40);
        issue_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        tick();
        issue_ready  = 1'b0;
        branch_taken = 1'b0;
        chk("hb_addr",  imem_addr, 32'h100);
        chk("hb_valid", 32'(issue_valid), 32'd0);

        // PC wrap from 0xFFFF_FFFC
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1000_0001;
        tick();
        chk("wr_pcout", pc_out, 32'hFFFF_FFFC);
        // Stray ack while issuing must not overwrite the buffer
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("stray_instr", instr, 32'h1000_0001);
        chk("stray_valid", 32'(issue_valid), 32'd1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("wr_next", imem_addr, 32'd0);

        // Halt
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hF000_0000;
        tick();
        imem_ack    = 1'b0;
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("h_halted", 32'(halted), 32'd1);
        chk("h_valid",  32'(issue_valid), 32'd0);
        chk("h_addr",   imem_addr, 32'd0);
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("h_req",  32'(imem_req), 32'd0);
            chk("h_stay", 32'(halted), 32'd1);
        end
        branch_taken = 1'b0;
        chk("h_noredir", imem_addr, 32'd0);
        rst = 1'b1;
        #1;
        chk("hr_halted", 32'(halted), 32'd0);
        chk("hr_req",    32'(imem_req), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("hr_req2",  32'(imem_req), 32'd1);
        chk("hr_addr",  imem_addr, 32'd0);

        // Reset during WAIT with ack arriving in reset
        tick();
        tick();
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        chk("rw_addr", imem_addr, 32'h200);
        tick();
        rst = 1'b1;
        #1;
        chk("rw_req", 32'(imem_req), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        tick();
        imem_ack = 1'b0;
        rst      = 1'b0;
        #1;
        chk("rw_freq",  32'(imem_req), 32'd1);
        chk("rw_faddr", imem_addr, 32'd0);
        chk("rw_instr", instr, 32'd0);
        tick();
        tick();
        chk("rw_nov", 32'(issue_valid), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h4000_0000;
        tick();
        imem_ack = 1'b0;
        chk("rw_valid", 32'(issue_valid), 32'd1);
        chk("rw_new",   instr, 32'h4000_0000);
        chk("rw_pcout", pc_out, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
